dispatch_nw: RTL

- Parametrised W-wide successor of the single-issue dispatch stage. Sits between decode and the RAT, freelist, ROB and the NUM_RS reservation stations.
- Holds one decoded group of up to WIDTH uops in a holding register and dispatches the longest in-order prefix whose resources are available each cycle. Undispatched slots shift down to slot 0.
- Resolves intra-group RAW and WAW dependencies, allocates consecutive ROB slots and freelist PDs, supports flush, and keeps a saturating stall counter.

---
 rtl/dispatch_nw.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dispatch_nw.sv
// dispatch_nw: W-wide dispatch stage between decode and RAT/freelist/ROB/RS.
// Holds one decoded group and each cycle dispatches the longest in-order
// prefix of held uops whose ROB, freelist and RS resources are all available.
// Undispatched slots shift down to slot 0. Intra-group RAW/WAW hazards are
// resolved by bypassing the new PD of an earlier writer in the same group.
// Ports:
//   clk, rst_n, flush         clock, async active-low reset, redirect
//   in_*                      incoming decoded group; in_ready = accepted
//   rat_*                     RAT lookup (same-cycle response) and remap writes
//   fl_*                      freelist offer / consume count
//   rob_*                     ROB free count, tail index, per-slot enqueue
//   rs_*                      one enqueue channel per reservation station
//   stall_cycles              saturating count of fully blocked cycles
module dispatch_nw #(
  parameter int WIDTH     = 2,
  parameter int NUM_RS    = 4,
  parameter int PHYS_W    = 6,
  parameter int ROB_IDX_W = 5,
  parameter int PAYLOAD_W = 128,
  localparam int FK_W     = (NUM_RS > 1) ? $clog2(NUM_RS) : 1,
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              in_valid,
  output logic                          in_ready,
  input  logic [WIDTH*5-1:0]            in_rs1,
  input  logic [WIDTH*5-1:0]            in_rs2,
  input  logic [WIDTH*5-1:0]            in_rd,
  input  logic [WIDTH-1:0]              in_dest_we,
  input  logic [WIDTH*FK_W-1:0]         in_fukind,
  input  logic [WIDTH*PAYLOAD_W-1:0]    in_payload,
  output logic [WIDTH*5-1:0]            rat_rs1,
  output logic [WIDTH*5-1:0]            rat_rs2,
  output logic [WIDTH*5-1:0]            rat_rd,
  input  logic [WIDTH*PHYS_W-1:0]       rat_ps1,
  input  logic [WIDTH*PHYS_W-1:0]       rat_ps2,
  input  logic [WIDTH*PHYS_W-1:0]       rat_old_pd,
  input  logic [WIDTH-1:0]              rat_ps1_rdy,
  input  logic [WIDTH-1:0]              rat_ps2_rdy,
  output logic [WIDTH-1:0]              rat_we,
  output logic [WIDTH*5-1:0]            rat_wr_rd,
  output logic [WIDTH*PHYS_W-1:0]       rat_wr_pd,
  input  logic [CNT_W-1:0]              fl_avail,
  input  logic [WIDTH*PHYS_W-1:0]       fl_pd,
  output logic [CNT_W-1:0]              fl_pop,
  input  logic [CNT_W-1:0]              rob_free,
  input  logic [ROB_IDX_W-1:0]          rob_tail,
  output logic [WIDTH-1:0]              rob_alloc,
  output logic [WIDTH*5-1:0]            rob_rd,
  output logic [WIDTH*PHYS_W-1:0]       rob_pd,
  output logic [WIDTH*PHYS_W-1:0]       rob_pd_old,
  output logic [WIDTH-1:0]              rob_dest_we,
  output logic [WIDTH*PAYLOAD_W-1:0]    rob_payload,
  input  logic [NUM_RS-1:0]             rs_enq_ready,
  output logic [NUM_RS-1:0]             rs_enq_valid,
  output logic [NUM_RS*PHYS_W-1:0]      rs_ps1,
  output logic [NUM_RS*PHYS_W-1:0]      rs_ps2,
  output logic [NUM_RS*PHYS_W-1:0]      rs_pd,
  output logic [NUM_RS-1:0]             rs_rs1_rdy,
  output logic [NUM_RS-1:0]             rs_rs2_rdy,
  output logic [NUM_RS-1:0]             rs_dest_we,
  output logic [NUM_RS*ROB_IDX_W-1:0]   rs_rob_idx,
  output logic [NUM_RS*PAYLOAD_W-1:0]   rs_payload,
  output logic [31:0]                   stall_cycles
);

  // Holding register
  logic [WIDTH-1:0]     hold_v_q, hold_v_d;
  logic [WIDTH-1:0]     we_q, we_d;
  logic [4:0]           rs1_q [WIDTH], rs1_d [WIDTH];
  logic [4:0]           rs2_q [WIDTH], rs2_d [WIDTH];
  logic [4:0]           rd_q  [WIDTH], rd_d  [WIDTH];
  logic [FK_W-1:0]      fk_q  [WIDTH], fk_d  [WIDTH];
  logic [PAYLOAD_W-1:0] pay_q [WIDTH], pay_d [WIDTH];
  logic [31:0]          stall_q, stall_d;

  // Per-slot dispatch decisions
  logic [WIDTH-1:0]     writer, fire, rdy1, rdy2;
  logic [PHYS_W-1:0]    pd [WIDTH], old_pd [WIDTH], ps1 [WIDTH], ps2 [WIDTH];
  logic [ROB_IDX_W-1:0] rob_idx [WIDTH];
  logic [CNT_W-1:0]     wcnt, k, nvalid, pop;
  logic [NUM_RS-1:0]    used;
  logic                 chain, rs_ok;

  always_comb begin
    writer = '0;
    fire   = '0;
    wcnt   = '0;
    used   = '0;
    k      = '0;
    nvalid = '0;
    pop    = '0;
    rs_ok  = 1'b0;
    chain  = ~flush;
    for (int i = 0; i < WIDTH; i++) begin
      writer[i] = hold_v_q[i] & we_q[i] & (rd_q[i] != 5'd0);
      // wcnt counts writers before slot i: that is its freelist position.
      pd[i] = '0;
      for (int n = 0; n < WIDTH; n++)
        if (writer[i] && wcnt == CNT_W'(n)) pd[i] = fl_pd[n*PHYS_W +: PHYS_W];
      if (writer[i]) wcnt = wcnt + CNT_W'(1);
      rs_ok = 1'b0;
      for (int r = 0; r < NUM_RS; r++)
        if (fk_q[i] == FK_W'(r)) rs_ok = rs_enq_ready[r] & ~used[r];
      // chain carries "all earlier slots fired", so firing is always a prefix.
      chain = chain & hold_v_q[i] & (CNT_W'(i) < rob_free) & (wcnt <= fl_avail) & rs_ok;
      fire[i] = chain;
      for (int r = 0; r < NUM_RS; r++)
        if (chain && fk_q[i] == FK_W'(r)) used[r] = 1'b1;
      if (chain)              k      = k + CNT_W'(1);
      if (hold_v_q[i])        nvalid = nvalid + CNT_W'(1);
      if (chain && writer[i]) pop    = pop + CNT_W'(1);
    end

    // Bypass: ascending j leaves the highest earlier matching writer in place.
    // writer[j] implies rd_j != 0, so x0 sources never match.
    for (int i = 0; i < WIDTH; i++) begin
      ps1[i]    = rat_ps1[i*PHYS_W +: PHYS_W];
      ps2[i]    = rat_ps2[i*PHYS_W +: PHYS_W];
      rdy1[i]   = rat_ps1_rdy[i];
      rdy2[i]   = rat_ps2_rdy[i];
      old_pd[i] = writer[i] ? rat_old_pd[i*PHYS_W +: PHYS_W] : '0;
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && writer[j]) begin
          if (rd_q[j] == rs1_q[i]) begin
            ps1[i]  = pd[j];
            rdy1[i] = 1'b0;
          end
          if (rd_q[j] == rs2_q[i]) begin
            ps2[i]  = pd[j];
            rdy2[i] = 1'b0;
          end
          if (writer[i] && rd_q[j] == rd_q[i]) old_pd[i] = pd[j];
        end
      end
    end
  end

  assign in_ready     = ~flush & (k == nvalid);
  assign fl_pop       = pop;
  assign stall_cycles = stall_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
    assign rob_idx[gi]                         = rob_tail + ROB_IDX_W'(gi);
    assign rat_rs1[gi*5 +: 5]                  = hold_v_q[gi] ? rs1_q[gi] : 5'd0;
    assign rat_rs2[gi*5 +: 5]                  = hold_v_q[gi] ? rs2_q[gi] : 5'd0;
    assign rat_rd[gi*5 +: 5]                   = hold_v_q[gi] ? rd_q[gi] : 5'd0;
    assign rat_we[gi]                          = fire[gi] & writer[gi];
    assign rat_wr_rd[gi*5 +: 5]                = hold_v_q[gi] ? rd_q[gi] : 5'd0;
    assign rat_wr_pd[gi*PHYS_W +: PHYS_W]      = pd[gi];
    assign rob_alloc[gi]                       = fire[gi];
    assign rob_rd[gi*5 +: 5]                   = hold_v_q[gi] ? rd_q[gi] : 5'd0;
    assign rob_pd[gi*PHYS_W +: PHYS_W]         = pd[gi];
    assign rob_pd_old[gi*PHYS_W +: PHYS_W]     = old_pd[gi];
    assign rob_dest_we[gi]                     = fire[gi] & writer[gi];
    assign rob_payload[gi*PAYLOAD_W +: PAYLOAD_W] = hold_v_q[gi] ? pay_q[gi] : '0;
  end

  // RS routing: at most one firing slot per fukind, so no priority is needed.
  logic [NUM_RS-1:0]    ch_v, ch_r1, ch_r2, ch_we;
  logic [PHYS_W-1:0]    ch_ps1 [NUM_RS], ch_ps2 [NUM_RS], ch_pd [NUM_RS];
  logic [ROB_IDX_W-1:0] ch_idx [NUM_RS];
  logic [PAYLOAD_W-1:0] ch_pay [NUM_RS];

  always_comb begin
    ch_v  = '0;
    ch_r1 = '0;
    ch_r2 = '0;
    ch_we = '0;
    for (int r = 0; r < NUM_RS; r++) begin
      ch_ps1[r] = '0;
      ch_ps2[r] = '0;
      ch_pd[r]  = '0;
      ch_idx[r] = '0;
      ch_pay[r] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int r = 0; r < NUM_RS; r++) begin
        if (fire[i] && fk_q[i] == FK_W'(r)) begin
          ch_v[r]   = 1'b1;
          ch_ps1[r] = ps1[i];
          ch_ps2[r] = ps2[i];
          ch_r1[r]  = rdy1[i];
          ch_r2[r]  = rdy2[i];
          ch_pd[r]  = pd[i];
          ch_we[r]  = writer[i];
          ch_idx[r] = rob_idx[i];
          ch_pay[r] = pay_q[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_rs
    assign rs_enq_valid[gi]                       = ch_v[gi];
    assign rs_ps1[gi*PHYS_W +: PHYS_W]            = ch_ps1[gi];
    assign rs_ps2[gi*PHYS_W +: PHYS_W]            = ch_ps2[gi];
    assign rs_pd[gi*PHYS_W +: PHYS_W]             = ch_pd[gi];
    assign rs_rs1_rdy[gi]                         = ch_r1[gi];
    assign rs_rs2_rdy[gi]                         = ch_r2[gi];
    assign rs_dest_we[gi]                         = ch_we[gi];
    assign rs_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W]  = ch_idx[gi];
    assign rs_payload[gi*PAYLOAD_W +: PAYLOAD_W]  = ch_pay[gi];
  end

  // Next state: flush clears, full drain loads (or empties on a bubble),
  // partial drain shifts the remaining slots down by k.
  always_comb begin
    hold_v_d = hold_v_q;
    we_d     = we_q;
    for (int i = 0; i < WIDTH; i++) begin
      rs1_d[i] = rs1_q[i];
      rs2_d[i] = rs2_q[i];
      rd_d[i]  = rd_q[i];
      fk_d[i]  = fk_q[i];
      pay_d[i] = pay_q[i];
    end
    if (flush) begin
      hold_v_d = '0;
    end else if (k == nvalid) begin
      hold_v_d = in_valid;
      if (|in_valid) begin
        we_d = in_dest_we;
        for (int i = 0; i < WIDTH; i++) begin
          rs1_d[i] = in_rs1[i*5 +: 5];
          rs2_d[i] = in_rs2[i*5 +: 5];
          rd_d[i]  = in_rd[i*5 +: 5];
          fk_d[i]  = in_fukind[i*FK_W +: FK_W];
          pay_d[i] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_v_d[i] = 1'b0;
        for (int s = 0; s < WIDTH; s++) begin
          if (s >= i && k == CNT_W'(s - i)) begin
            hold_v_d[i] = hold_v_q[s];
            we_d[i]     = we_q[s];
            rs1_d[i]    = rs1_q[s];
            rs2_d[i]    = rs2_q[s];
            rd_d[i]     = rd_q[s];
            fk_d[i]     = fk_q[s];
            pay_d[i]    = pay_q[s];
          end
        end
      end
    end
    stall_d = stall_q;
    if (|hold_v_q && k == '0 && !flush && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q <= '0;
      we_q     <= '0;
      stall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        rs1_q[i] <= '0;
        rs2_q[i] <= '0;
        rd_q[i]  <= '0;
        fk_q[i]  <= '0;
        pay_q[i] <= '0;
      end
    end else begin
      hold_v_q <= hold_v_d;
      we_q     <= we_d;
      stall_q  <= stall_d;
      for (int i = 0; i < WIDTH; i++) begin
        rs1_q[i] <= rs1_d[i];
        rs2_q[i] <= rs2_d[i];
        rd_q[i]  <= rd_d[i];
        fk_q[i]  <= fk_d[i];
        pay_q[i] <= pay_d[i];
      end
    end
  end

endmodule
